// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus: display read port, two write ports and the single-port RAM side.
// master = requesters plus RAM; slave = the arbiter.
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 15
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;

  logic              wa_valid;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              wa_ready;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output disp_req, disp_addr,
    input  disp_data, disp_valid,
    output wa_valid, wa_addr, wa_data,
    input  wa_ready,
    output wb_valid, wb_addr, wb_data,
    input  wb_ready,
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata
  );

  modport slave (
    input  disp_req, disp_addr,
    output disp_data, disp_valid,
    input  wa_valid, wa_addr, wa_data,
    output wa_ready,
    input  wb_valid, wb_addr, wb_data,
    output wb_ready,
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads pre-empt two round-robin writers; read data 2 cycles after request.
// Writers are back-pressured via wa_ready/wb_ready (no write buffering); the display is never stalled.
module vram_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 15,
  parameter int STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  vram_arbiter_if.slave      bus,
  output logic [STALL_W-1:0] wr_stall_cnt
);

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_DISP = 2'd1;
  localparam logic [1:0] GNT_WA   = 2'd2;
  localparam logic [1:0] GNT_WB   = 2'd3;

  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  logic [1:0]        grant;
  logic              prio_b;
  logic              rd_inflight;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c;
  logic              ram_we_c;
  logic              wr_stall;

  // prio_b selects which writer wins only when both are requesting
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (bus.disp_req) begin
        grant = GNT_DISP;
      end else if (bus.wa_valid && bus.wb_valid) begin
        grant = prio_b ? GNT_WB : GNT_WA;
      end else if (bus.wa_valid) begin
        grant = GNT_WA;
      end else if (bus.wb_valid) begin
        grant = GNT_WB;
      end
    end
  end

  always_comb begin
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    ram_we_c    = 1'b0;
    case (grant)
      GNT_DISP: begin
        ram_addr_c = bus.disp_addr;
      end
      GNT_WA: begin
        ram_addr_c  = bus.wa_addr;
        ram_wdata_c = bus.wa_data;
        ram_we_c    = 1'b1;
      end
      GNT_WB: begin
        ram_addr_c  = bus.wb_addr;
        ram_wdata_c = bus.wb_data;
        ram_we_c    = 1'b1;
      end
      default: begin
        ram_we_c = 1'b0;
      end
    endcase
  end

  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.wa_ready  = (grant == GNT_WA);
  assign bus.wb_ready  = (grant == GNT_WB);

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_b <= 1'b0;
    end else if (grant == GNT_WA) begin
      prio_b <= 1'b1;
    end else if (grant == GNT_WB) begin
      prio_b <= 1'b0;
    end
  end

  // Stage 1 marks the RAM read in flight; stage 2 captures ram_rdata.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_inflight  <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      rd_inflight  <= (grant == GNT_DISP);
      disp_valid_q <= rd_inflight;
      if (rd_inflight) begin
        disp_data_q <= bus.ram_rdata;
      end
    end
  end

  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_data_q;

  assign wr_stall = (bus.wa_valid || bus.wb_valid) && !(grant == GNT_WA || grant == GNT_WB);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_stall_cnt <= '0;
    end else if (wr_stall && (wr_stall_cnt != STALL_MAX)) begin
      wr_stall_cnt <= wr_stall_cnt + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed plus randomized bench for vram_arbiter with a behavioural RAM and reference model.
module tb_vram_arbiter;
  localparam int AW = 16;
  localparam int DW = 15;
  localparam int G_NONE = 0;
  localparam int G_DISP = 1;
  localparam int G_WA   = 2;
  localparam int G_WB   = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 ();
  logic [15:0] stall16;
  logic [3:0]  stall4;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STALL_W(16)) dut (
    .clock(clock), .reset(reset), .bus(bus), .wr_stall_cnt(stall16));

  // second instance sees identical requests; only its 4-bit stall counter is of interest
  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STALL_W(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4), .wr_stall_cnt(stall4));

  assign bus4.disp_req  = bus.disp_req;
  assign bus4.disp_addr = bus.disp_addr;
  assign bus4.wa_valid  = bus.wa_valid;
  assign bus4.wa_addr   = bus.wa_addr;
  assign bus4.wa_data   = bus.wa_data;
  assign bus4.wb_valid  = bus.wb_valid;
  assign bus4.wb_addr   = bus.wb_addr;
  assign bus4.wb_data   = bus.wb_data;
  assign bus4.ram_rdata = '0;

  // behavioural single-port RAM, one-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] mem_rd;
  always @(posedge clock) begin
    mem_rd = mem[bus.ram_addr];
    if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
    bus.ram_rdata <= mem_rd;
  end

  // reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            read_at [int];
  logic [DW-1:0] read_val [int];
  bit            rst_at [int];
  logic [DW-1:0] exp_data;
  int  stall_cycles;
  bit  next_is_b;
  int  last_g;
  int  cyc;
  int  passed;
  int  total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic cycle();
    int g;
    bit exp_valid;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    #1;
    g = G_NONE;
    if (!reset) begin
      if (bus.disp_req)                       g = G_DISP;
      else if (bus.wa_valid && bus.wb_valid)  g = next_is_b ? G_WB : G_WA;
      else if (bus.wa_valid)                  g = G_WA;
      else if (bus.wb_valid)                  g = G_WB;
    end
    ea = (g == G_DISP) ? bus.disp_addr : (g == G_WA) ? bus.wa_addr : (g == G_WB) ? bus.wb_addr : '0;
    ed = (g == G_WA) ? bus.wa_data : (g == G_WB) ? bus.wb_data : '0;
    chk("wa_ready", 32'(bus.wa_ready), 32'(g == G_WA));
    chk("wb_ready", 32'(bus.wb_ready), 32'(g == G_WB));
    chk("ram_we",   32'(bus.ram_we),   32'(g == G_WA || g == G_WB));
    chk("ram_addr", 32'(bus.ram_addr), 32'(ea));
    if (g != G_DISP) chk("ram_wdata", 32'(bus.ram_wdata), 32'(ed));

    read_at[cyc] = (g == G_DISP);
    if (g == G_DISP) read_val[cyc] = ref_mem[bus.disp_addr];
    if (g == G_WA) ref_mem[bus.wa_addr] = bus.wa_data;
    if (g == G_WB) ref_mem[bus.wb_addr] = bus.wb_data;
    rst_at[cyc] = reset;
    if (reset) begin
      stall_cycles = 0;
      next_is_b = 1'b0;
    end else begin
      if ((bus.wa_valid || bus.wb_valid) && g != G_WA && g != G_WB) stall_cycles++;
      if (g == G_WA) next_is_b = 1'b1;
      if (g == G_WB) next_is_b = 1'b0;
    end
    last_g = g;

    @(posedge clock);
    #1;
    // a read shows up two cycles after issue unless reset was sampled in between
    exp_valid = !rst_at[cyc] && (cyc >= 1) && read_at.exists(cyc - 1) && read_at[cyc - 1];
    if (rst_at[cyc]) exp_data = '0;
    else if (exp_valid) exp_data = read_val[cyc - 1];
    chk("disp_valid", 32'(bus.disp_valid), 32'(exp_valid));
    chk("disp_data",  32'(bus.disp_data),  32'(exp_data));
    chk("stall16", 32'(stall16), 32'((stall_cycles > 65535) ? 65535 : stall_cycles));
    chk("stall4",  32'(stall4),  32'((stall_cycles > 15) ? 15 : stall_cycles));
    cyc++;
  endtask

  // writers keep their request stable until accepted, then may present a new one
  task automatic refresh_writers(input bit force_a, input bit force_b);
    if (last_g == G_WA || !bus.wa_valid) begin
      bus.wa_valid = force_a | ($urandom_range(0, 1) == 1);
      bus.wa_addr  = AW'($urandom_range(0, 255));
      bus.wa_data  = DW'($urandom);
    end
    if (last_g == G_WB || !bus.wb_valid) begin
      bus.wb_valid = force_b | ($urandom_range(0, 1) == 1);
      bus.wb_addr  = AW'($urandom_range(0, 255));
      bus.wb_data  = DW'($urandom);
    end
  endtask

  initial begin
    passed = 0; total = 0; cyc = 0;
    stall_cycles = 0; next_is_b = 1'b0; last_g = G_NONE; exp_data = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'(i + 'h100);
      ref_mem[i] = DW'(i + 'h100);
    end

    // reset with every requester active: nothing may be granted
    reset = 1'b1;
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0010;
    bus.wa_valid = 1'b1; bus.wa_addr = 16'h0020; bus.wa_data = 15'h0aaa;
    bus.wb_valid = 1'b1; bus.wb_addr = 16'h0030; bus.wb_data = 15'h0555;
    for (int i = 0; i < 3; i++) cycle();
    chk("reset_disp_valid", 32'(bus.disp_valid), 32'd0);
    chk("reset_stall", 32'(stall16), 32'd0);

    reset = 1'b0;
    bus.disp_req = 1'b0; bus.wa_valid = 1'b0; bus.wb_valid = 1'b0;

    // display-only burst of four reads
    for (int i = 0; i < 4; i++) begin
      bus.disp_req = 1'b1; bus.disp_addr = AW'(i);
      cycle();
    end
    bus.disp_req = 1'b0;
    cycle();
    chk("burst_last_data", 32'(bus.disp_data), 32'h103);
    cycle();
    cycle();

    // dual writer contention: alternating A,B,A,B,A,B
    bus.wa_valid = 1'b1; bus.wb_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("contention_a", 32'(bus.wa_ready), 32'(i % 2 == 0));
      cycle();
      refresh_writers(1'b1, 1'b1);
    end
    chk("contention_stall", 32'(stall16), 32'd0);
    bus.wa_valid = 1'b0; bus.wb_valid = 1'b0;
    cycle();

    // display blocks writer A for ten cycles
    bus.wa_valid = 1'b1; bus.wa_addr = 16'h0040; bus.wa_data = 15'h0123;
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0041;
    for (int i = 0; i < 10; i++) cycle();
    chk("block_stall", 32'(stall16), 32'd10);
    bus.disp_req = 1'b0;
    #1;
    chk("block_release", 32'(bus.wa_ready), 32'd1);
    cycle();
    chk("block_stall_hold", 32'(stall16), 32'd10);
    bus.wa_valid = 1'b0;

    // read-after-write to 0x00FF
    bus.wa_valid = 1'b1; bus.wa_addr = 16'h00ff; bus.wa_data = 15'h1234;
    cycle();
    bus.wa_valid = 1'b0;
    bus.disp_req = 1'b1; bus.disp_addr = 16'h00ff;
    cycle();
    bus.disp_req = 1'b0;
    cycle();
    chk("raw_valid", 32'(bus.disp_valid), 32'd1);
    chk("raw_data",  32'(bus.disp_data),  32'h1234);

    // randomized traffic with occasional resets
    last_g = G_NONE;
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 59) == 0);
      bus.disp_req = ($urandom_range(0, 3) == 0);
      bus.disp_addr = AW'($urandom_range(0, 255));
      refresh_writers(1'b0, 1'b0);
      cycle();
    end

    // saturation of the 4-bit counter after a clean reset
    reset = 1'b1; bus.disp_req = 1'b0; bus.wa_valid = 1'b0; bus.wb_valid = 1'b0;
    cycle();
    reset = 1'b0;
    bus.wa_valid = 1'b1; bus.wa_addr = 16'h0050; bus.wa_data = 15'h0777;
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0005;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_stall4", 32'(stall4), 32'd15);
    chk("sat_stall16", 32'(stall16), 32'd20);

    // two reads in flight when reset arrives
    bus.disp_addr = 16'h0006;
    cycle();
    bus.disp_addr = 16'h0007;
    cycle();
    reset = 1'b1; bus.disp_req = 1'b0; bus.wb_valid = 1'b1;
    cycle();
    chk("flush_valid", 32'(bus.disp_valid), 32'd0);
    chk("flush_stall", 32'(stall16), 32'd0);
    cycle();
    reset = 1'b0;
    #1;
    chk("post_reset_grant_a", 32'(bus.wa_ready), 32'd1);
    cycle();
    cycle();
    chk("post_reset_no_stale", 32'(bus.disp_valid), 32'd0);
    bus.wa_valid = 1'b0; bus.wb_valid = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameters: ADDR_W, default 16, VRAM address width; DATA_W, default 15, pixel width (RGB555); STALL_W, default 16, stall-counter width.
REQ-002 clock  input  1  system clock (pixel clock domain); all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 disp_req  input  1  display read request; one read per asserted cycle.
REQ-005 disp_addr  input  ADDR_W  display read address.
REQ-006 disp_data  output  DATA_W  display read data, registered.
REQ-007 disp_valid  output  1  disp_data holds the result of the read issued two cycles earlier.
REQ-008 wa_valid / wa_addr / wa_data  input  1 / ADDR_W / DATA_W  writer A request, address, data.
REQ-009 wa_ready  output  1  writer A granted this cycle.
REQ-010 wb_valid / wb_addr / wb_data  input  1 / ADDR_W / DATA_W  writer B request, address, data.
REQ-011 wb_ready  output  1  writer B granted this cycle.
REQ-012 ram_addr / ram_wdata / ram_we  output  ADDR_W / DATA_W / 1  single-port VRAM address, write data, write enable.
REQ-013 ram_rdata  input  DATA_W  VRAM read data, valid one cycle after address presented.
REQ-014 wr_stall_cnt  output  STALL_W  saturating count of cycles in which at least one writer was valid but none was granted.

Function
REQ-015 Each cycle exactly one grant SHALL be issued from {DISP, WA, WB, NONE}, decided combinationally from the current inputs and the registered priority pointer.
REQ-016 disp_req SHALL have absolute priority: disp_req=1 -> grant DISP, wa_ready=wb_ready=0, regardless of writer state.
REQ-017 With disp_req=0 and only one writer valid, that writer SHALL be granted.
REQ-018 With disp_req=0 and both writers valid, the writer indicated by the priority pointer SHALL be granted.
REQ-019 Priority pointer: 1-bit register, reset value = A; after a WA grant -> B; after a WB grant -> A; unchanged on DISP or NONE cycles.
REQ-020 wX_ready SHALL be 1 only when wX_valid=1 and X is granted; a transfer occurs on a cycle with wX_valid & wX_ready.
REQ-021 Writers SHALL hold valid/addr/data stable until accepted; the arbiter does not buffer writes.
REQ-022 Grant DISP: ram_addr=disp_addr, ram_we=0. Grant WX: ram_addr=wX_addr, ram_wdata=wX_data, ram_we=1. Grant NONE: ram_we=0, ram_addr/ram_wdata = 0.
REQ-023 Display read pipeline: disp_req at cycle N -> ram_rdata sampled at N+1 into disp_data -> disp_data/disp_valid visible at N+2; fixed two-cycle latency, one read per cycle, no bubbles for back-to-back requests.
REQ-024 disp_valid SHALL be 0 in cycles with no read issued two cycles earlier; disp_data SHALL hold its last value.
REQ-025 A write and a display read to the same address in consecutive cycles SHALL be executed in grant order (no reordering); read-after-write returns the written data.
REQ-026 wr_stall_cnt SHALL increment by 1 in each cycle with (wa_valid|wb_valid) & ~(wa_ready|wb_ready), saturate at 2^STALL_W-1, and never wrap.
REQ-027 A cycle where both writers are valid and one is granted SHALL NOT count as a stall.

Reset
REQ-028 While reset=1: grant NONE, ram_we=0, wa_ready=wb_ready=0, disp_valid=0, disp_data=0, priority pointer=A, wr_stall_cnt=0, read pipeline flushed.
REQ-029 Reads in flight when reset is asserted SHALL be discarded; the first disp_valid after reset deassertion corresponds to a read issued after deassertion.

Verification
REQ-030 Display only: disp_req=1 for addr 0x0000..0x0003 on 4 consecutive cycles, RAM preloaded addr->addr+0x100 -> disp_valid=1 on cycles 2..5 with disp_data 0x100..0x103 in order.
REQ-031 Contention: both writers valid continuously, disp_req=0, 6 cycles -> grants A,B,A,B,A,B; ram_we=1 every cycle; wr_stall_cnt stays 0.
REQ-032 Display blocks writers: wa_valid=1 and disp_req=1 for 10 cycles -> wa_ready=0 throughout, ram_we=0, wr_stall_cnt=10; disp_req drops -> wa_ready=1 next cycle, wr_stall_cnt holds at 10.
REQ-033 RAW: WA writes 0x1234 to 0x00FF at cycle N, disp_req for 0x00FF at N+1 -> disp_data=0x1234, disp_valid=1 at N+3.
REQ-034 Saturation/reset: STALL_W=4, writer blocked 20 cycles -> wr_stall_cnt=15; reset asserted mid-read with 2 reads in flight -> disp_valid=0, wr_stall_cnt=0, pointer=A, next dual-writer grant is A.
